cam_cfg_seq: RTL and testbench

Sequencer for the OV5640 I2C configuration engine. It walks a register table held in an external synchronous ROM/BRAM and issues one 32-bit write per entry to the I2C configuration engine (`configure_en`/`configure_data`/`configure_rdy`). It handles inline delay entries, end-of-table markers, per-write timeouts and bounded retries. It sits between the camera reset block (`initial_en`) and the I2C engine, and it replaces software-driven `CONFIG_EN`/`CONFIG_DA` at power-up.

---
 rtl/cam_cfg_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_cam_cfg_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cfg_seq.sv
`default_nettype none
// =====================================================================
// Module   : cam_cfg_seq
// Brief    : Walks an OV5640 register table in a synchronous ROM and
//            issues one write per entry to the I2C configuration engine.
// Revision : 1.0 - initial release
// =====================================================================
module cam_cfg_seq #(
    parameter int TBL_AWID  = 8,
    parameter int TBL_LEN   = 252,
    parameter int MS_CYC    = 24000,
    parameter int GAP_CYC   = 240,
    parameter int TO_CYC    = 2400000,
    parameter int RETRY_MAX = 3
) (
    input  logic                clk_24m,
    input  logic                rst_n,
    input  logic                initial_en,
    input  logic                restart,
    output logic                tbl_rd,
    output logic [TBL_AWID-1:0] tbl_addr,
    input  logic [31:0]         tbl_data,
    output logic                configure_en,
    output logic [31:0]         configure_data,
    input  logic                configure_rdy,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [TBL_AWID-1:0] err_idx
);

    localparam int c_GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
    localparam int c_TO_W  = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
    localparam int c_RT_W  = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    localparam logic [c_GAP_W-1:0]  c_GAP_LAST = c_GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [c_TO_W-1:0]   c_TO_LAST  = c_TO_W'((TO_CYC > 0) ? TO_CYC - 1 : 0);
    localparam logic [c_RT_W-1:0]   c_RT_MAX   = c_RT_W'(RETRY_MAX);
    localparam logic [TBL_AWID:0]   c_LEN      = (TBL_AWID + 1)'(TBL_LEN);
    localparam logic [31:0]         c_MS       = 32'(MS_CYC);
    localparam logic [31:0]         c_END_MARK = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_WAIT_RDY  = 4'd3,
        S_ISSUE     = 4'd4,
        S_WAIT_BUSY = 4'd5,
        S_WAIT_DONE = 4'd6,
        S_GAP       = 4'd7,
        S_DELAY     = 4'd8,
        S_END       = 4'd9,
        S_ERR       = 4'd10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [TBL_AWID:0]   r_idx;
    logic [TBL_AWID:0]   w_idx_inc;
    logic [TBL_AWID:0]   w_fetch_idx;
    logic [c_RT_W-1:0]   r_retry;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [31:0]         r_dly_cnt;
    logic [31:0]         r_dly_last;
    logic [31:0]         r_word;
    logic [31:0]         w_dly_len;

    logic                w_wait;
    logic                w_to_hit;
    logic                w_to_clr;
    logic                w_retry;
    logic                w_go_err;
    logic                w_entry_ok;
    logic                w_adv;
    logic                w_clear_all;

    logic                r_tbl_rd;
    logic [TBL_AWID-1:0] r_tbl_addr;
    logic                r_cfg_en;
    logic [31:0]         r_cfg_data;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [TBL_AWID-1:0] r_err_idx;

    assign w_idx_inc   = r_idx + 1'b1;
    assign w_fetch_idx = w_adv ? w_idx_inc : r_idx;
    assign w_to_hit    = (r_to_cnt == c_TO_LAST);
    assign w_dly_len   = {16'd0, tbl_data[15:0]} * c_MS;

    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait      = 1'b0;
        w_to_clr    = 1'b0;
        w_retry     = 1'b0;
        w_go_err    = 1'b0;
        w_entry_ok  = 1'b0;
        w_adv       = 1'b0;
        w_clear_all = 1'b0;

        if (restart) begin
            w_state_nxt = S_IDLE;
            w_clear_all = 1'b1;
        end else if (!initial_en && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_clear_all = 1'b1;
        end else begin
            case (r_state)
                S_IDLE:      if (initial_en) w_state_nxt = S_FETCH;
                S_FETCH:     w_state_nxt = S_DECODE;
                S_DECODE: begin
                    if (tbl_data == c_END_MARK) begin
                        w_state_nxt = S_END;
                    end else if (tbl_data[31:24] == 8'h00) begin
                        // A zero-length delay advances straight to the next entry
                        if (tbl_data[15:0] == 16'd0) w_adv = 1'b1;
                        else                         w_state_nxt = S_DELAY;
                    end else begin
                        w_state_nxt = S_WAIT_RDY;
                        w_to_clr    = 1'b1;
                    end
                end
                S_WAIT_RDY:  if (configure_rdy) w_state_nxt = S_ISSUE;  else w_wait = 1'b1;
                S_ISSUE:     w_state_nxt = S_WAIT_BUSY;
                S_WAIT_BUSY: if (!configure_rdy) w_state_nxt = S_WAIT_DONE; else w_wait = 1'b1;
                S_WAIT_DONE: begin
                    if (configure_rdy) begin
                        w_state_nxt = S_GAP;
                        w_entry_ok  = 1'b1;
                    end else begin
                        w_wait = 1'b1;
                    end
                end
                S_GAP:       if (r_gap_cnt == c_GAP_LAST) w_adv = 1'b1;
                S_DELAY:     if (r_dly_cnt == r_dly_last) w_adv = 1'b1;
                S_END:       w_state_nxt = S_END;
                S_ERR:       w_state_nxt = S_ERR;
                default:     w_state_nxt = S_IDLE;
            endcase

            // Progress in a wait state takes precedence over a coincident timeout
            if (w_wait && w_to_hit) begin
                if (r_retry < c_RT_MAX) begin
                    w_state_nxt = S_WAIT_RDY;
                    w_retry     = 1'b1;
                    w_to_clr    = 1'b1;
                end else begin
                    w_state_nxt = S_ERR;
                    w_go_err    = 1'b1;
                end
            end

            if (w_adv) begin
                w_state_nxt = (w_idx_inc == c_LEN) ? S_END : S_FETCH;
            end
        end
    end

    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_retry    <= '0;
            r_to_cnt   <= '0;
            r_gap_cnt  <= '0;
            r_dly_cnt  <= '0;
            r_dly_last <= '0;
            r_word     <= '0;
        end else begin
            if (w_clear_all) begin
                r_idx   <= '0;
                r_retry <= '0;
            end else begin
                if (w_adv) r_idx <= w_idx_inc;
                if (w_retry)         r_retry <= r_retry + 1'b1;
                else if (w_entry_ok) r_retry <= '0;
            end

            if (w_to_clr)    r_to_cnt <= '0;
            else if (w_wait) r_to_cnt <= r_to_cnt + 1'b1;

            r_gap_cnt <= (r_state == S_GAP)   ? r_gap_cnt + 1'b1 : '0;
            r_dly_cnt <= (r_state == S_DELAY) ? r_dly_cnt + 32'd1 : '0;

            if (r_state == S_DECODE) begin
                r_word     <= tbl_data;
                r_dly_last <= w_dly_len - 32'd1;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_tbl_rd   <= 1'b0;
            r_tbl_addr <= '0;
            r_cfg_en   <= 1'b0;
            r_cfg_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_idx  <= '0;
        end else begin
            r_tbl_rd <= (w_state_nxt == S_FETCH);
            if (w_state_nxt == S_FETCH) r_tbl_addr <= w_fetch_idx[TBL_AWID-1:0];

            r_cfg_en <= (w_state_nxt == S_ISSUE);
            if (w_state_nxt == S_ISSUE) r_cfg_data <= r_word;

            r_busy <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_END) && (w_state_nxt != S_ERR);

            if (w_clear_all)           r_done <= 1'b0;
            else if (r_state == S_END) r_done <= 1'b1;

            if (w_clear_all) begin
                r_error <= 1'b0;
            end else if (w_go_err) begin
                r_error   <= 1'b1;
                r_err_idx <= r_idx[TBL_AWID-1:0];
            end
        end
    end

    assign tbl_rd         = r_tbl_rd;
    assign tbl_addr       = r_tbl_addr;
    assign configure_en   = r_cfg_en;
    assign configure_data = r_cfg_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign err_idx        = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_cam_cfg_seq.sv
`default_nettype none
// =====================================================================
// Module   : tb_cam_cfg_seq
// Brief    : Self-checking bench for cam_cfg_seq with ROM and I2C engine models.
// Revision : 1.0 - initial release
// =====================================================================
module tb_cam_cfg_seq;

    localparam int c_AW       = 4;
    localparam int c_LEN      = 8;
    localparam int c_MS       = 20;
    localparam int c_GAP      = 5;
    localparam int c_TO       = 1000;
    localparam int c_RT       = 3;
    localparam int c_ENG_BUSY = 100;

    logic            clk_24m = 1'b0;
    logic            rst_n = 1'b0;
    logic            initial_en = 1'b0;
    logic            restart = 1'b0;
    logic            tbl_rd;
    logic [c_AW-1:0] tbl_addr;
    logic [31:0]     tbl_data;
    logic            configure_en;
    logic [31:0]     configure_data;
    logic            configure_rdy;
    logic            busy;
    logic            done;
    logic            error;
    logic [c_AW-1:0] err_idx;

    int              total = 0;
    int              bad = 0;
    logic [31:0]     rom [16];
    logic [31:0]     sb [$];
    int              en_hist [$];
    int              cmpl_hist [$];
    int              cyc = 0;
    int              n_pulse = 0;
    int              n_fetch = 0;
    int              eng_cnt = 0;
    logic [c_AW-1:0] last_fetch = '0;
    logic [c_AW-1:0] max_fetch = '0;
    bit              stuck = 1'b0;
    bit              rd_pend = 1'b0;
    logic [c_AW-1:0] rd_addr = '0;

    always #5 clk_24m = ~clk_24m;

    cam_cfg_seq #(
        .TBL_AWID  (c_AW),
        .TBL_LEN   (c_LEN),
        .MS_CYC    (c_MS),
        .GAP_CYC   (c_GAP),
        .TO_CYC    (c_TO),
        .RETRY_MAX (c_RT)
    ) u_dut (
        .clk_24m        (clk_24m),
        .rst_n          (rst_n),
        .initial_en     (initial_en),
        .restart        (restart),
        .tbl_rd         (tbl_rd),
        .tbl_addr       (tbl_addr),
        .tbl_data       (tbl_data),
        .configure_en   (configure_en),
        .configure_data (configure_data),
        .configure_rdy  (configure_rdy),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_idx        (err_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wword(input int i);
        return {16'h7830, 8'(i), 8'(8'hA0 + i)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_24m);
        #2;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    task automatic load_plain();
        for (int i = 0; i < 16; i++) rom[i] = wword(i);
    endtask

    task automatic push_exp(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) sb.push_back(wword(i));
    endtask

    task automatic wait_until(input int sel, input int target, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick(1);
            case (sel)
                0:       hit = done;
                1:       hit = error;
                2:       hit = (n_pulse >= target);
                default: hit = (n_fetch >= target);
            endcase
        end
        if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Synchronous ROM, I2C engine model and scoreboard consumer
    initial begin
        configure_rdy = 1'b1;
        tbl_data      = '0;
        forever begin
            @(posedge clk_24m);
            #1;
            cyc++;
            if (rd_pend) tbl_data = rom[rd_addr];
            rd_pend = tbl_rd;
            rd_addr = tbl_addr;
            if (tbl_rd) begin
                n_fetch++;
                last_fetch = tbl_addr;
                if (tbl_addr > max_fetch) max_fetch = tbl_addr;
            end
            if (configure_en) begin
                n_pulse++;
                en_hist.push_back(cyc);
                if (sb.size() > 0) check("cfg_data", configure_data, sb.pop_front());
                else               check("extra_pulse", 32'd1, 32'd0);
                if (!stuck) begin
                    configure_rdy = 1'b0;
                    eng_cnt       = c_ENG_BUSY;
                end
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    configure_rdy = 1'b1;
                    cmpl_hist.push_back(cyc);
                end
            end
        end
    end

    initial begin
        int base_p;
        int base_f;

        tick(3);
        check("rst_tbl_rd",   32'(tbl_rd),         32'd0);
        check("rst_tbl_addr", 32'(tbl_addr),       32'd0);
        check("rst_cfg_en",   32'(configure_en),   32'd0);
        check("rst_cfg_data", configure_data,      32'd0);
        check("rst_busy",     32'(busy),           32'd0);
        check("rst_done",     32'(done),           32'd0);
        check("rst_error",    32'(error),          32'd0);
        check("rst_err_idx",  32'(err_idx),        32'd0);

        // Two writes around a 2-unit delay, stopped by the end marker
        load_plain();
        rom[0] = 32'h7830_0802;
        rom[1] = 32'h0000_0002;
        rom[2] = 32'h7831_0300;
        rom[3] = 32'hFFFF_FFFF;
        sb.push_back(32'h7830_0802);
        sb.push_back(32'h7831_0300);
        en_hist.delete();
        cmpl_hist.delete();
        base_p = n_pulse;
        base_f = n_fetch;
        rst_n      = 1'b1;
        initial_en = 1'b1;
        wait_until(0, 0, 2000, "t1_done");
        check("t1_pulses", 32'(n_pulse - base_p), 32'd2);
        check("t1_fetches", 32'(n_fetch - base_f), 32'd4);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        if (en_hist.size() >= 2 && cmpl_hist.size() >= 1)
            check("t1_delay", 32'((en_hist[1] - cmpl_hist[0]) >= (2 * c_MS + c_GAP)), 32'd1);
        else
            check("t1_hist", 32'd0, 32'd1);
        check("t1_sb", 32'(sb.size()), 32'd0);

        // Full table, no end marker: stops after entry TBL_LEN-1
        load_plain();
        push_exp(0, c_LEN - 1);
        max_fetch = '0;
        base_p = n_pulse;
        base_f = n_fetch;
        pulse_restart();
        check("t2_done_clr", 32'(done), 32'd0);
        wait_until(0, 0, 3000, "t2_done");
        check("t2_pulses", 32'(n_pulse - base_p), 32'(c_LEN));
        check("t2_fetches", 32'(n_fetch - base_f), 32'(c_LEN));
        check("t2_max_addr", 32'(max_fetch), 32'(c_LEN - 1));
        check("t2_done", 32'(done), 32'd1);
        check("t2_sb", 32'(sb.size()), 32'd0);

        // Engine never accepts: one try plus RETRY_MAX retries, then error
        stuck = 1'b1;
        for (int i = 0; i <= c_RT; i++) sb.push_back(wword(0));
        base_p = n_pulse;
        pulse_restart();
        wait_until(1, 0, 8000, "t3_err");
        check("t3_pulses", 32'(n_pulse - base_p), 32'(c_RT + 1));
        check("t3_error", 32'(error), 32'd1);
        check("t3_err_idx", 32'(err_idx), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        tick(2500);
        check("t3_quiet", 32'(n_pulse - base_p), 32'(c_RT + 1));
        check("t3_hold", 32'(error), 32'd1);
        check("t3_sb", 32'(sb.size()), 32'd0);

        // Restart out of ERR reruns from entry 0
        stuck = 1'b0;
        push_exp(0, c_LEN - 1);
        base_p = n_pulse;
        base_f = n_fetch;
        pulse_restart();
        check("t4_err_clr", 32'(error), 32'd0);
        wait_until(3, base_f + 1, 50, "t4_fetch");
        check("t4_first_addr", 32'(last_fetch), 32'd0);
        wait_until(0, 0, 3000, "t4_done");
        check("t4_pulses", 32'(n_pulse - base_p), 32'(c_LEN));
        check("t4_sb", 32'(sb.size()), 32'd0);

        // Drop initial_en while entry 5 is in flight
        push_exp(0, 5);
        base_p = n_pulse;
        pulse_restart();
        wait_until(2, base_p + 6, 3000, "t5_e5");
        tick(20);
        check("t5_busy_pre", 32'(busy), 32'd1);
        initial_en = 1'b0;
        tick(1);
        check("t5_busy_abort", 32'(busy), 32'd0);
        check("t5_done_abort", 32'(done), 32'd0);
        tick(150);
        check("t5_quiet", 32'(n_pulse - base_p), 32'd6);
        check("t5_sb", 32'(sb.size()), 32'd0);
        push_exp(0, c_LEN - 1);
        base_p = n_pulse;
        base_f = n_fetch;
        initial_en = 1'b1;
        wait_until(3, base_f + 1, 50, "t5_fetch");
        check("t5_first_addr", 32'(last_fetch), 32'd0);
        wait_until(0, 0, 3000, "t5_done");
        check("t5_pulses", 32'(n_pulse - base_p), 32'(c_LEN));
        check("t5_sb_end", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-sequence, checked before the next clock edge
        push_exp(0, c_LEN - 1);
        base_p = n_pulse;
        pulse_restart();
        wait_until(2, base_p + 2, 1000, "t6_run");
        tick(30);
        #4;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cfg_data", configure_data, 32'd0);
        check("t6_tbl_addr", 32'(tbl_addr), 32'd0);
        check("t6_cfg_en", 32'(configure_en), 32'd0);
        check("t6_tbl_rd", 32'(tbl_rd), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_error", 32'(error), 32'd0);
        sb.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
